// File: rtl/uart_pkg.sv
// Shared UART definitions: frame size, receiver state encoding and bit-period helper.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } uart_state_e;

  // Last count of one bit period for the given clock and line rate.
  function automatic int unsigned clk_count(input int unsigned clock_freq,
                                            input int unsigned baud_rate);
    return clock_freq / baud_rate - 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
    end
  end

  assign rx_s = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and one-cycle valid / frame_err strobes.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each mid-bit point.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned CLOCK_FREQ = 12_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned CLK_COUNT  = clk_count(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_COUNT = CLK_COUNT / 2;
  localparam int unsigned CNT_W      = $clog2(CLK_COUNT + 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 sample;

`ifdef UART_RX_MAJORITY_EN
  // Decision lands one count after the centre, so the start check shifts by one and the
  // later decisions at CLK_COUNT already sit one cycle past their centres.
  localparam int unsigned START_DEC = HALF_COUNT + 1;
  logic [1:0] hist_q, hist_d;
  assign hist_d = {hist_q[0], rx_s};
  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  localparam int unsigned START_DEC = HALF_COUNT;
  assign sample = rx_s;
`endif

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = (state_q == StIdle) ? '0 : clk_cnt_q + 1'b1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (clk_cnt_q == CNT_W'(START_DEC)) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = sample ? StIdle : StData;
        end
      end
      StData: begin
        if (clk_cnt_q == CNT_W'(CLK_COUNT)) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = sample;
          if (bit_idx_q == 3'(DATA_BITS - 1)) state_d = StStop;
          else bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      StStop: begin
        if (clk_cnt_q == CNT_W'(CLK_COUNT)) begin
          clk_cnt_d = '0;
          if (sample) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end
      end
      StBreak: begin
        // Wait for the line to return high so a held-low line reports only once.
        if (rx_s) begin
          clk_cnt_d = '0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      hist_q      <= 2'b11;
`endif
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_MAJORITY_EN
      hist_q      <= hist_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are driven bit by bit and expected strobes are
// queued at frame start, then matched against the DUT's valid / frame_err pulses.
module tb_uart_rx;

  localparam int BIT_CYC = 104;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // Negedges from driving the start edge to seeing the strobe.
  localparam int LAT = 991 + MAJ;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t        sb[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] model_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    ev_t e;
    if (!rst && (valid || frame_err)) begin
      if (sb.size() == 0) begin
        check_val("unexpected_strobe", {30'b0, frame_err, valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_val("strobe_kind", {30'b0, frame_err, valid}, e.is_err ? 32'd2 : 32'd1);
        check_val("strobe_data", {24'b0, data}, {24'b0, e.data});
        check_val("strobe_cycle", cyc, e.cyc);
      end
    end
  end

  // exp_kind: 0 = no strobe expected, 1 = valid, 2 = frame_err. Call on a negedge.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit glitch,
                            input int exp_kind);
    logic [9:0] bits;
    ev_t        e;
    bits = {stop, b, 1'b0};
    if (exp_kind == 1) begin
      e.is_err = 1'b0; e.data = b; e.cyc = cyc + LAT;
      sb.push_back(e);
      model_data = b;
    end else if (exp_kind == 2) begin
      e.is_err = 1'b1; e.data = model_data; e.cyc = cyc + LAT;
      sb.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < BIT_CYC; k++) begin
        rx = (glitch && k == BIT_CYC / 2) ? 1'b0 : bits[i];
        @(negedge clk);
      end
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int         busy_cnt;
    logic [9:0] abort_bits;
    rst = 1'b0;
    rx  = 1'b1;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_data", {24'b0, data}, 32'h0);
    check_val("rst_valid", {31'b0, valid}, 32'h0);
    check_val("rst_frame_err", {31'b0, frame_err}, 32'h0);
    check_val("rst_busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;
    idle(10);

    // Clean frame.
    send_frame(8'hA5, 1'b1, 1'b0, 1);
    idle(20);
    check_val("busy_after_a5", {31'b0, busy}, 32'h0);

    // Short low pulse is rejected at the start-bit mid-point.
    busy_cnt = 0;
    for (int j = 0; j < 120; j++) begin
      rx = (j < 20) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check_val("glitch_busy_cycles", busy_cnt, 52 + MAJ);

    // Stop bit low, line held low afterwards.
    send_frame(8'h3C, 1'b0, 1'b0, 2);
    rx = 1'b0;
    repeat (500) @(negedge clk);
    check_val("busy_in_break", {31'b0, busy}, 32'h1);
    idle(10);
    check_val("busy_after_break", {31'b0, busy}, 32'h0);
    idle(10);

    // Back-to-back frames with a single stop bit.
    send_frame(8'h00, 1'b1, 1'b0, 1);
    send_frame(8'hFF, 1'b1, 1'b0, 1);
    idle(20);

    // Reset in the middle of bit 4 of 0x5A.
    abort_bits = {1'b1, 8'h5A, 1'b0};
    for (int j = 0; j < 5 * BIT_CYC + BIT_CYC / 2; j++) begin
      rx = abort_bits[j / BIT_CYC];
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check_val("midrst_data", {24'b0, data}, 32'h0);
    check_val("midrst_valid", {31'b0, valid}, 32'h0);
    check_val("midrst_frame_err", {31'b0, frame_err}, 32'h0);
    check_val("midrst_busy", {31'b0, busy}, 32'h0);
    model_data = 8'h00;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    idle(20);
    send_frame(8'h81, 1'b1, 1'b0, 1);
    idle(20);

    // One-cycle low glitch on every sample point of an 0xFF frame.
`ifdef UART_RX_MAJORITY_EN
    send_frame(8'hFF, 1'b1, 1'b1, 1);
`else
    send_frame(8'hFF, 1'b1, 1'b1, 2);
`endif
    idle(50);
    check_val("sb_empty", sb.size(), 32'd0);
    check_val("final_busy", {31'b0, busy}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
